// File: rtl/psram_pkg.sv
// Shared types and default timing for the PSRAM asynchronous read path.
// Halfword addresses are 22 bits per die; the die is selected by word address bit 21.
package psram_pkg;

   localparam int DEF_ADDR_CYCLES     = 2;
   localparam int DEF_READ_CYCLES     = 6;
   localparam int DEF_RECOVERY_CYCLES = 1;

   localparam int HW_ADDR_W = 22;
   localparam int DIE_BIT   = 21;

   typedef enum logic [2:0] {
      IDLE,
      ADDR_LO,
      READ_LO,
      RECOV_LO,
      ADDR_HI,
      READ_HI,
      RECOV_HI
   } rd_state_e;

   typedef enum logic [1:0] {
      PH_IDLE,
      PH_ADDR,
      PH_READ,
      PH_RECOV
   } cyc_phase_e;

   function automatic int phase_cnt_w(input int a, input int r, input int c);
      int m;
      m = a;
      if (r > m) m = r;
      if (c > m) m = c;
      return $clog2(m) + 1;
   endfunction

endpackage

// File: rtl/psram_async_read_cycle.sv
// One asynchronous-mode halfword read: ADDR (ADV# low, address on DQ), READ (OE# low), RECOV.
// All pin outputs are registered so DQ drive and OE# always change on the same edge.
module psram_async_read_cycle
   import psram_pkg::*;
#(
   parameter int ADDR_CYCLES     = DEF_ADDR_CYCLES,
   parameter int READ_CYCLES     = DEF_READ_CYCLES,
   parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 start,
   input  logic                 die,
   input  logic [HW_ADDR_W-1:0] hw_addr,
   input  logic [15:0]          dq_in,
   output logic [5:0]           a,
   output logic [15:0]          dq_out,
   output logic                 dq_oe,
   output logic                 ce0_n,
   output logic                 ce1_n,
   output logic                 adv_n,
   output logic                 oe_n,
   output logic                 ub_n,
   output logic                 lb_n,
   output logic [15:0]          rd_data,
   output logic                 rd_sample,
   output logic                 phase_end,
   output logic                 done
);

   localparam int CNT_W = phase_cnt_w(ADDR_CYCLES, READ_CYCLES, RECOVERY_CYCLES);
   localparam logic [CNT_W-1:0] ADDR_LD  = CNT_W'(ADDR_CYCLES - 1);
   localparam logic [CNT_W-1:0] READ_LD  = CNT_W'(READ_CYCLES - 1);
   localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RECOVERY_CYCLES - 1);

   cyc_phase_e       phase;
   logic [CNT_W-1:0] cnt;
   logic             launch;

   assign phase_end = (phase != PH_IDLE) && (cnt == '0);
   assign rd_sample = (phase == PH_READ) && (cnt == '0);
   assign done      = (phase == PH_RECOV) && (cnt == '0);
   assign rd_data   = dq_in;
   // A new access may start straight out of the last recovery cycle.
   assign launch    = start && ((phase == PH_IDLE) || done);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase  <= PH_IDLE;
         cnt    <= '0;
         a      <= '0;
         dq_out <= '0;
         dq_oe  <= 1'b0;
         ce0_n  <= 1'b1;
         ce1_n  <= 1'b1;
         adv_n  <= 1'b1;
         oe_n   <= 1'b1;
         ub_n   <= 1'b1;
         lb_n   <= 1'b1;
      end else if (launch) begin
         phase  <= PH_ADDR;
         cnt    <= ADDR_LD;
         a      <= hw_addr[21:16];
         dq_out <= hw_addr[15:0];
         dq_oe  <= 1'b1;
         ce0_n  <= die;
         ce1_n  <= ~die;
         adv_n  <= 1'b0;
         oe_n   <= 1'b1;
         ub_n   <= 1'b0;
         lb_n   <= 1'b0;
      end else if (phase != PH_IDLE) begin
         if (cnt != '0) begin
            cnt <= cnt - 1'b1;
         end else begin
            case (phase)
               PH_ADDR: begin
                  phase  <= PH_READ;
                  cnt    <= READ_LD;
                  adv_n  <= 1'b1;
                  dq_oe  <= 1'b0;
                  dq_out <= '0;
                  oe_n   <= 1'b0;
               end
               PH_READ: begin
                  phase <= PH_RECOV;
                  cnt   <= RECOV_LD;
                  ce0_n <= 1'b1;
                  ce1_n <= 1'b1;
                  oe_n  <= 1'b1;
                  ub_n  <= 1'b1;
                  lb_n  <= 1'b1;
               end
               default: begin
                  phase <= PH_IDLE;
                  a     <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: rtl/psram_bridge_reader.sv
// 32-bit bridge read port: two halfword PSRAM reads (even address first) assembled little-endian.
// The die bit is captured at acceptance and held for both halves, so the top word never wraps dies.
module psram_bridge_reader
   import psram_pkg::*;
#(
   parameter int ADDR_CYCLES     = DEF_ADDR_CYCLES,
   parameter int READ_CYCLES     = DEF_READ_CYCLES,
   parameter int RECOVERY_CYCLES = DEF_RECOVERY_CYCLES
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic [HW_ADDR_W-1:0] req_addr,
   output logic                 rsp_valid,
   output logic [31:0]          rsp_data,
   output logic                 busy,
   output logic [5:0]           psram_a,
   output logic [15:0]          psram_dq_out,
   output logic                 psram_dq_oe,
   input  logic [15:0]          psram_dq_in,
   output logic                 psram_ce0_n,
   output logic                 psram_ce1_n,
   output logic                 psram_adv_n,
   output logic                 psram_oe_n,
   output logic                 psram_we_n,
   output logic                 psram_ub_n,
   output logic                 psram_lb_n,
   output logic                 psram_cre,
   input  logic                 psram_wait_n
);

   if (ADDR_CYCLES < 1 || READ_CYCLES < 1 || RECOVERY_CYCLES < 1) begin : g_param_check
      $error("psram_bridge_reader: ADDR/READ/RECOVERY cycle counts must all be >= 1");
   end

   rd_state_e            state;
   logic [HW_ADDR_W-1:0] addr_q;
   logic                 accept;
   logic                 cyc_start;
   logic                 cyc_die;
   logic [HW_ADDR_W-1:0] cyc_addr;
   logic [15:0]          rd_data;
   logic                 rd_sample;
   logic                 phase_end;
   logic                 cyc_done;
   logic                 unused_wait;

   assign accept    = req_valid && req_ready;
   assign cyc_start = accept || ((state == RECOV_LO) && cyc_done);
   // On acceptance the low half is launched from the live request; the high half from the capture.
   assign cyc_die   = accept ? req_addr[DIE_BIT] : addr_q[DIE_BIT];
   assign cyc_addr  = accept ? {req_addr[DIE_BIT-1:0], 1'b0} : {addr_q[DIE_BIT-1:0], 1'b1};

   assign busy        = ~req_ready;
   assign psram_we_n  = 1'b1;
   assign psram_cre   = 1'b0;
   assign unused_wait = psram_wait_n;

   psram_async_read_cycle #(
      .ADDR_CYCLES    (ADDR_CYCLES),
      .READ_CYCLES    (READ_CYCLES),
      .RECOVERY_CYCLES(RECOVERY_CYCLES)
   ) u_cycle (
      .clk      (clk),
      .reset_n  (reset_n),
      .start    (cyc_start),
      .die      (cyc_die),
      .hw_addr  (cyc_addr),
      .dq_in    (psram_dq_in),
      .a        (psram_a),
      .dq_out   (psram_dq_out),
      .dq_oe    (psram_dq_oe),
      .ce0_n    (psram_ce0_n),
      .ce1_n    (psram_ce1_n),
      .adv_n    (psram_adv_n),
      .oe_n     (psram_oe_n),
      .ub_n     (psram_ub_n),
      .lb_n     (psram_lb_n),
      .rd_data  (rd_data),
      .rd_sample(rd_sample),
      .phase_end(phase_end),
      .done     (cyc_done)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         addr_q    <= '0;
         req_ready <= 1'b1;
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  addr_q    <= req_addr;
                  req_ready <= 1'b0;
                  state     <= ADDR_LO;
               end
            end
            ADDR_LO: if (phase_end) state <= READ_LO;
            READ_LO: begin
               if (rd_sample) begin
                  rsp_data[15:0] <= rd_data;
                  state          <= RECOV_LO;
               end
            end
            RECOV_LO: if (cyc_done) state <= ADDR_HI;
            ADDR_HI:  if (phase_end) state <= READ_HI;
            READ_HI: begin
               if (rd_sample) begin
                  rsp_data[31:16] <= rd_data;
                  rsp_valid       <= 1'b1;
                  state           <= RECOV_HI;
               end
            end
            RECOV_HI: begin
               if (cyc_done) begin
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: begin
               req_ready <= 1'b1;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_psram_bridge_reader.sv
// Bench for psram_bridge_reader: behavioural PSRAM with access-time check plus word-level expectations.
module tb_psram_bridge_reader;

   localparam int A = 2;
   localparam int R = 6;
   localparam int C = 1;
   localparam int LAT_VLD = 1 + 2*A + 2*R + C;
   localparam int LAT_RDY = 1 + 2*(A + R + C);
   localparam int PERIOD  = 2*(A + R + C) + 1;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic [21:0] req_addr = '0;
   logic        rsp_valid;
   logic [31:0] rsp_data;
   logic        busy;
   logic [5:0]  psram_a;
   logic [15:0] psram_dq_out;
   logic        psram_dq_oe;
   logic [15:0] psram_dq_in = 16'hDEAD;
   logic        psram_ce0_n, psram_ce1_n, psram_adv_n, psram_oe_n;
   logic        psram_we_n, psram_ub_n, psram_lb_n, psram_cre;
   logic        psram_wait_n = 1'b1;

   int n_checks = 0;
   int n_pass   = 0;

   always #5 clk = ~clk;

   psram_bridge_reader #(
      .ADDR_CYCLES(A), .READ_CYCLES(R), .RECOVERY_CYCLES(C)
   ) dut (
      .clk(clk), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy),
      .psram_a(psram_a), .psram_dq_out(psram_dq_out), .psram_dq_oe(psram_dq_oe),
      .psram_dq_in(psram_dq_in),
      .psram_ce0_n(psram_ce0_n), .psram_ce1_n(psram_ce1_n), .psram_adv_n(psram_adv_n),
      .psram_oe_n(psram_oe_n), .psram_we_n(psram_we_n), .psram_ub_n(psram_ub_n),
      .psram_lb_n(psram_lb_n), .psram_cre(psram_cre), .psram_wait_n(psram_wait_n)
   );

   // PSRAM model: memory keyed by {die, halfword address}; data only valid after R cycles of OE# low.
   logic [15:0] mem [logic [22:0]];
   logic [22:0] lat_key = '0;
   int          oe_cnt  = 0;
   logic        ce_act;
   assign ce_act = !psram_ce0_n || !psram_ce1_n;

   function automatic logic [15:0] mem_rd(input logic [22:0] k);
      if (mem.exists(k)) return mem[k];
      return k[15:0] ^ 16'hA5C3;
   endfunction

   function automatic logic [31:0] exp_word(input logic [21:0] wa);
      logic [22:0] lo;
      logic [22:0] hi;
      lo = {wa[21], wa[20:0], 1'b0};
      hi = {wa[21], wa[20:0], 1'b1};
      return {mem_rd(hi), mem_rd(lo)};
   endfunction

   task automatic preload(input logic [21:0] wa);
      mem[{wa[21], wa[20:0], 1'b0}] = 16'($urandom);
      mem[{wa[21], wa[20:0], 1'b1}] = 16'($urandom);
      mem[{~wa[21], wa[20:0], 1'b0}] = 16'($urandom);
      mem[{~wa[21], wa[20:0], 1'b1}] = 16'($urandom);
   endtask

   always @(posedge clk) begin
      if (!psram_adv_n && ce_act) lat_key <= {psram_ce0_n, psram_a, psram_dq_out};
      if (!psram_oe_n && ce_act) oe_cnt <= oe_cnt + 1;
      else oe_cnt <= 0;
   end

   always @(negedge clk)
      psram_dq_in <= (ce_act && !psram_oe_n && oe_cnt >= R-1) ? mem_rd(lat_key) : 16'hDEAD;

   // Per-transaction observations (cycle k = k-th cycle after the accept edge)
   int          w_vld_cnt, w_vld_cyc, w_rdy_cyc;
   logic [31:0] w_data;
   bit          w_ce0, w_ce1, w_clash, w_adv_bad, w_const_bad, w_busy_bad;
   logic [21:0] w_addrs[$];

   function automatic logic [21:0] q_at(input int i);
      if (i < w_addrs.size()) return w_addrs[i];
      return 'x;
   endfunction

   task automatic issue(input logic [21:0] wa);
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = wa;
      @(posedge clk);
   endtask

   task automatic watch(input int ncyc);
      w_vld_cnt = 0; w_vld_cyc = -1; w_rdy_cyc = -1; w_data = 'x;
      w_ce0 = 0; w_ce1 = 0; w_clash = 0; w_adv_bad = 0; w_const_bad = 0; w_busy_bad = 0;
      w_addrs.delete();
      for (int k = 1; k <= ncyc; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
         if (rsp_valid) begin
            w_vld_cnt++;
            if (w_vld_cyc < 0) begin w_vld_cyc = k; w_data = rsp_data; end
         end
         if (req_ready && w_rdy_cyc < 0) w_rdy_cyc = k;
         if (!psram_ce0_n) w_ce0 = 1;
         if (!psram_ce1_n) w_ce1 = 1;
         if (psram_dq_oe && !psram_oe_n) w_clash = 1;
         if (!psram_adv_n && !psram_dq_oe) w_adv_bad = 1;
         if (psram_we_n !== 1'b1 || psram_cre !== 1'b0) w_const_bad = 1;
         if (busy !== ~req_ready) w_busy_bad = 1;
         if (!psram_adv_n) w_addrs.push_back({psram_a, psram_dq_out});
      end
   endtask

   task automatic test_reset();
      logic [11:0] got;
      repeat (2) @(negedge clk);
      got = {req_ready, busy, rsp_valid, psram_ce0_n, psram_ce1_n, psram_adv_n,
             psram_oe_n, psram_we_n, psram_ub_n, psram_lb_n, psram_cre, psram_dq_oe};
      n_checks++;
      if (got !== 12'b1001_1111_1100) $display("FAIL reset_ctrl got %b exp %b", got, 12'b1001_1111_1100);
      else n_pass++;
      n_checks++;
      if (rsp_data !== 32'h0) $display("FAIL reset_rsp_data got %h exp 0", rsp_data); else n_pass++;
      n_checks++;
      if ({psram_a, psram_dq_out} !== 22'h0)
         $display("FAIL reset_bus got a=%h dq=%h exp 0", psram_a, psram_dq_out);
      else n_pass++;
   endtask

   task automatic test_read_after_reset();
      mem[23'h000000] = 16'h5678;
      mem[23'h000001] = 16'h1234;
      @(negedge clk);
      req_valid = 1'b1;
      req_addr  = 22'h0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      watch(22);
      n_checks++;
      if (w_vld_cyc !== LAT_VLD) $display("FAIL rar_latency got %0d exp %0d", w_vld_cyc, LAT_VLD); else n_pass++;
      n_checks++;
      if (w_vld_cnt !== 1) $display("FAIL rar_pulses got %0d exp 1", w_vld_cnt); else n_pass++;
      n_checks++;
      if (w_data !== 32'h12345678) $display("FAIL rar_data got %h exp 12345678", w_data); else n_pass++;
      n_checks++;
      if ({w_ce0, w_ce1} !== 2'b10) $display("FAIL rar_die got ce0/ce1 used=%b exp 10", {w_ce0, w_ce1}); else n_pass++;
      n_checks++;
      if (w_rdy_cyc !== LAT_RDY) $display("FAIL rar_ready got %0d exp %0d", w_rdy_cyc, LAT_RDY); else n_pass++;
      n_checks++;
      if (w_busy_bad !== 1'b0) $display("FAIL rar_busy got busy!=~ready exp consistent"); else n_pass++;
   endtask

   task automatic test_die_select();
      preload(22'h200010);
      issue(22'h200010);
      watch(22);
      n_checks++;
      if ({w_ce0, w_ce1} !== 2'b01) $display("FAIL die_ce got used=%b exp 01", {w_ce0, w_ce1}); else n_pass++;
      n_checks++;
      if (w_addrs.size() !== 2*A) $display("FAIL die_adv_cycles got %0d exp %0d", w_addrs.size(), 2*A); else n_pass++;
      n_checks++;
      if (q_at(0) !== 22'h000020) $display("FAIL die_addr_lo got %h exp 000020", q_at(0)); else n_pass++;
      n_checks++;
      if (q_at(A) !== 22'h000021) $display("FAIL die_addr_hi got %h exp 000021", q_at(A)); else n_pass++;
      n_checks++;
      if (w_data !== exp_word(22'h200010)) $display("FAIL die_data got %h exp %h", w_data, exp_word(22'h200010)); else n_pass++;
   endtask

   task automatic test_top_address();
      preload(22'h3FFFFF);
      issue(22'h3FFFFF);
      watch(22);
      n_checks++;
      if ({w_ce0, w_ce1} !== 2'b01) $display("FAIL top_ce got used=%b exp 01", {w_ce0, w_ce1}); else n_pass++;
      n_checks++;
      if (q_at(0) !== 22'h3FFFFE) $display("FAIL top_addr_lo got %h exp 3ffffe", q_at(0)); else n_pass++;
      n_checks++;
      if (q_at(A) !== 22'h3FFFFF) $display("FAIL top_addr_hi got %h exp 3fffff", q_at(A)); else n_pass++;
      n_checks++;
      if (w_data !== exp_word(22'h3FFFFF)) $display("FAIL top_data got %h exp %h", w_data, exp_word(22'h3FFFFF)); else n_pass++;
   endtask

   task automatic test_random_reads();
      logic [21:0] wa;
      for (int i = 0; i < 6; i++) begin
         wa = 22'($urandom);
         preload(wa);
         issue(wa);
         watch(22);
         n_checks++;
         if (w_data !== exp_word(wa)) $display("FAIL rnd%0d_data addr %h got %h exp %h", i, wa, w_data, exp_word(wa)); else n_pass++;
         n_checks++;
         if (w_vld_cyc !== LAT_VLD || w_vld_cnt !== 1)
            $display("FAIL rnd%0d_valid got cyc %0d cnt %0d exp cyc %0d cnt 1", i, w_vld_cyc, w_vld_cnt, LAT_VLD);
         else n_pass++;
         n_checks++;
         if (w_rdy_cyc !== LAT_RDY) $display("FAIL rnd%0d_ready got %0d exp %0d", i, w_rdy_cyc, LAT_RDY); else n_pass++;
         n_checks++;
         if ({w_ce0, w_ce1} !== (wa[21] ? 2'b01 : 2'b10))
            $display("FAIL rnd%0d_die addr %h got used=%b", i, wa, {w_ce0, w_ce1});
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      int          acc[$];
      int          rcyc[$];
      logic [31:0] rdat[$];
      int          n_sent;
      int          got_i;
      int          exp_i;
      n_sent = 0;
      for (int i = 5; i <= 7; i++) preload(22'(i));
      for (int k = 0; k < 80; k++) begin
         @(negedge clk);
         if (rsp_valid) begin rcyc.push_back(k); rdat.push_back(rsp_data); end
         if (req_ready && n_sent < 3) begin
            req_valid = 1'b1;
            req_addr  = 22'(5 + n_sent);
            acc.push_back(k);
            n_sent++;
         end else if (n_sent >= 3) begin
            req_valid = 1'b0;
         end else begin
            req_addr = 22'($urandom);
         end
      end
      req_valid = 1'b0;
      n_checks++;
      if (acc.size() !== 3 || rcyc.size() !== 3)
         $display("FAIL b2b_counts got accepts %0d responses %0d exp 3 3", acc.size(), rcyc.size());
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         got_i = (i < rcyc.size()) ? rcyc[i] : -1;
         exp_i = (i < acc.size()) ? acc[i] + LAT_VLD : -2;
         n_checks++;
         if (got_i !== exp_i) $display("FAIL b2b%0d_latency got cycle %0d exp %0d", i, got_i, exp_i); else n_pass++;
         n_checks++;
         if (i >= rdat.size() || rdat[i] !== exp_word(22'(5 + i)))
            $display("FAIL b2b%0d_data got %h exp %h", i, (i < rdat.size()) ? rdat[i] : 32'hx, exp_word(22'(5 + i)));
         else n_pass++;
      end
      for (int i = 1; i < 3; i++) begin
         got_i = (i < acc.size()) ? acc[i] - acc[i-1] : -1;
         n_checks++;
         if (got_i !== PERIOD) $display("FAIL b2b%0d_spacing got %0d exp %0d", i, got_i, PERIOD); else n_pass++;
      end
   endtask

   task automatic test_bus_contention();
      logic [21:0] wa;
      wa = 22'($urandom);
      preload(wa);
      issue(wa);
      watch(22);
      n_checks++;
      if (w_clash !== 1'b0) $display("FAIL bus_dq_vs_oe got overlap=1 exp 0"); else n_pass++;
      n_checks++;
      if (w_adv_bad !== 1'b0) $display("FAIL bus_adv_without_dq got 1 exp 0"); else n_pass++;
      n_checks++;
      if (w_const_bad !== 1'b0) $display("FAIL bus_we_cre_const got changed exp constant"); else n_pass++;
      n_checks++;
      if (w_data !== exp_word(wa)) $display("FAIL bus_data got %h exp %h", w_data, exp_word(wa)); else n_pass++;
   endtask

   task automatic test_reset_mid_read();
      logic [21:0] wa;
      logic [9:0]  got;
      wa = 22'($urandom);
      preload(wa);
      issue(wa);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (k == 1) req_valid = 1'b0;
      end
      n_checks++;
      if (psram_oe_n !== 1'b0) $display("FAIL mid_pre_read got oe_n=%b exp 0", psram_oe_n); else n_pass++;
      reset_n = 1'b0;
      #1;
      got = {psram_ce0_n, psram_ce1_n, psram_adv_n, psram_oe_n, psram_we_n,
             psram_ub_n, psram_lb_n, psram_dq_oe, req_ready, rsp_valid};
      n_checks++;
      if (got !== 10'b1111111_0_1_0) $display("FAIL mid_reset_outputs got %b exp 1111111010", got); else n_pass++;
      n_checks++;
      if (rsp_data !== 32'h0) $display("FAIL mid_reset_data got %h exp 0", rsp_data); else n_pass++;
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      watch(25);
      n_checks++;
      if (w_vld_cnt !== 0) $display("FAIL mid_no_response got %0d pulses exp 0", w_vld_cnt); else n_pass++;
      wa = 22'($urandom);
      preload(wa);
      issue(wa);
      watch(22);
      n_checks++;
      if (w_data !== exp_word(wa) || w_vld_cyc !== LAT_VLD)
         $display("FAIL mid_recovery got %h at %0d exp %h at %0d", w_data, w_vld_cyc, exp_word(wa), LAT_VLD);
      else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_read_after_reset();
      test_die_select();
      test_back_to_back();
      test_bus_contention();
      test_top_address();
      test_random_reads();
      test_reset_mid_read();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
